// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Instruction-fetch front end for the IF/ID register. Owns the PC, issues
//   one request at a time to a variable-latency instruction memory, and
//   queues returned instructions together with their NPC in a small FIFO so
//   that decode stalls do not stop fetch. A taken-branch redirect flushes the
//   FIFO and discards any return belonging to the wrong path.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  PC loaded at reset (word aligned)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   imem_req     fetch request (registered)
//   imem_addr    word address being fetched, stable while imem_req=1
//   imem_ack     memory returns imem_data this cycle (ignored if !imem_req)
//   imem_data    instruction word, valid with imem_ack
//   redirect     taken branch/jump
//   redirect_pc  branch target (low 2 bits ignored)
//   stall        downstream cannot accept this cycle
//   valid        IR/NPC hold a real instruction
//   IR           FIFO head instruction, 0 when !valid
//   NPC          head instruction address + 4, 0 when !valid
// ---------------------------------------------------------------------------
module fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        valid,
   output logic [31:0] IR,
   output logic [31:0] NPC
);

   localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // IDLE: nothing outstanding. WAIT: outstanding, result will be kept.
   // DROP: outstanding, result belongs to a flushed path and is discarded.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                   state_q,   state_d;
   logic [31:0]              pc_q,      pc_d;
   logic                     req_q,     req_d;
   logic [31:0]              addr_q,    addr_d;
   logic [DEPTH-1:0][31:0]   ir_mem_q,  ir_mem_d;
   logic [DEPTH-1:0][31:0]   npc_mem_q, npc_mem_d;
   logic [PW-1:0]            rd_ptr_q,  rd_ptr_d;
   logic [PW-1:0]            wr_ptr_q,  wr_ptr_d;
   logic [CW-1:0]            count_q,   count_d;

   logic        push;
   logic        pop;
   logic        space;
   logic [31:0] pc_inc;
   logic [31:0] tgt_pc;
   logic        unused_pc_lsbs;

   assign pc_inc         = pc_q + 32'd4;   // wraps modulo 2^32
   assign tgt_pc         = {redirect_pc[31:2], 2'b00};
   assign unused_pc_lsbs = ^redirect_pc[1:0];

   // ------------------------------------------------------------------
   // FIFO: push only for a kept return, pop when the head is accepted.
   // A redirect empties the queue outright and wins over push and pop.
   // ------------------------------------------------------------------
   always_comb begin
      pop       = (count_q != '0) && !stall;
      push      = (state_q == S_WAIT) && imem_ack && !redirect;
      ir_mem_d  = ir_mem_q;
      npc_mem_d = npc_mem_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            // In WAIT the PC always equals the address being fetched.
            ir_mem_d[wr_ptr_q]  = imem_data;
            npc_mem_d[wr_ptr_q] = pc_inc;
            wr_ptr_d            = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      // A new request may only go out if a slot is reserved for its data,
      // judged on the occupancy after this edge's push/pop/flush.
      space = (count_d < DEPTH_C);
   end

   // ------------------------------------------------------------------
   // Fetch sequencer
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;

      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               pc_d = tgt_pc;
            end else if (space) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect) begin
               pc_d = tgt_pc;
               if (imem_ack) begin
                  req_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  // Memory still owes us this word; keep the handshake on
                  // the old address and throw the data away when it lands.
                  state_d = S_DROP;
               end
            end else if (imem_ack) begin
               pc_d = pc_inc;
               if (space) begin
                  addr_d = pc_inc;   // back-to-back fetch
               end else begin
                  req_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         S_DROP: begin
            if (imem_ack) begin
               if (redirect) begin
                  pc_d    = tgt_pc;
                  req_d   = 1'b0;
                  state_d = S_IDLE;
               end else if (space) begin
                  addr_d  = pc_q;
                  state_d = S_WAIT;
               end else begin
                  req_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end else if (redirect) begin
               pc_d = tgt_pc;
            end
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         req_q     <= 1'b0;
         addr_q    <= RESET_PC;
         ir_mem_q  <= '0;
         npc_mem_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         ir_mem_q  <= ir_mem_d;
         npc_mem_q <= npc_mem_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
      end
   end

   // Outputs are decoded from registers only.
   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign valid     = (count_q != '0);
   assign IR        = valid ? ir_mem_q[rd_ptr_q]  : 32'h0;
   assign NPC       = valid ? npc_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//   Directed bench for fetch_buffer. A behavioural instruction memory
//   (mem[a] = a | 0x1000, configurable ack latency) answers requests; every
//   instruction the DUT hands downstream is compared against a queue of
//   expected {IR, NPC} pairs filled by the stimulus. A second instance with
//   RESET_PC near the top of the address space exercises PC wrap.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic        valid;
   logic [31:0] IR;
   logic [31:0] NPC;

   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic        imem_ack2 = 1'b0;
   logic [31:0] imem_data2 = 32'h0;
   logic        redirect2 = 1'b0;
   logic [31:0] redirect_pc2 = 32'h0;
   logic        stall2 = 1'b0;
   logic        valid2;
   logic [31:0] IR2;
   logic [31:0] NPC2;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   int          lat = 0;
   int          cnt = 0;
   logic        mem_ovr = 1'b0;
   logic        ack_force = 1'b0;
   logic [31:0] data_force = 32'h0;

   always #5 clk = ~clk;

   fetch_buffer u_dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .valid       (valid),
      .IR          (IR),
      .NPC         (NPC)
   );

   fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req2),
      .imem_addr   (imem_addr2),
      .imem_ack    (imem_ack2),
      .imem_data   (imem_data2),
      .redirect    (redirect2),
      .redirect_pc (redirect_pc2),
      .stall       (stall2),
      .valid       (valid2),
      .IR          (IR2),
      .NPC         (NPC2)
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a | 32'h0000_1000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_seq(input logic [31:0] a, input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({mem_f(a + 32'(4 * k)), a + 32'(4 * k) + 32'd4});
      end
   endtask

   task automatic drain(input string tag, input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Memory model: acks 'lat' cycles after a request appears; the override
   // lets the stimulus force an ack regardless of the request.
   always @(negedge clk) begin
      if (mem_ovr) begin
         imem_ack  = ack_force;
         imem_data = data_force;
      end else begin
         if (imem_ack) cnt = 0;
         if (imem_req && cnt == lat) begin
            imem_ack  = 1'b1;
            imem_data = mem_f(imem_addr);
         end else begin
            imem_ack  = 1'b0;
            imem_data = 32'h0;
            cnt       = imem_req ? cnt + 1 : 0;
         end
      end
      imem_ack2  = 1'b1;
      imem_data2 = mem_f(imem_addr2);
   end

   // Scoreboard: an instruction leaves the DUT when valid && !stall at the
   // next edge, unless a redirect discards it.
   always @(negedge clk) begin
      if (reset && valid && !stall && !redirect && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("sb_ir", IR, mon_e[63:32]);
         chk("sb_npc", NPC, mon_e[31:0]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: no finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 reset = 1'b0;
      tick();
      tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_ir", IR, 32'h0);
      chk("rst_npc", NPC, 32'h0);
      chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

      // ---- streaming with ack tied high, then a long stall ----
      expect_seq(32'h0, 9);
      reset = 1'b1;
      tick();                                   // edge 1
      chk("e1_req", 32'(imem_req), 32'd1);
      chk("e1_addr", imem_addr, 32'h0);
      chk("e1_valid", 32'(valid), 32'd0);
      tick();                                   // edge 2
      chk("e2_valid", 32'(valid), 32'd1);
      chk("e2_ir", IR, 32'h0000_1000);
      chk("e2_npc", NPC, 32'h4);
      chk("wrap_e2_valid", 32'(valid2), 32'd1);
      chk("wrap_e2_ir", IR2, 32'hFFFF_FFF8);
      chk("wrap_e2_npc", NPC2, 32'hFFFF_FFFC);
      tick();                                   // edge 3
      chk("wrap_e3_ir", IR2, 32'hFFFF_FFFC);
      chk("wrap_e3_npc", NPC2, 32'h0);
      chk("wrap_e3_addr", imem_addr2, 32'h0);
      stall = 1'b1;
      for (int i = 0; i < 10; i++) begin        // edges 4..13
         tick();
         chk("stall_ir", IR, 32'h0000_1004);
         chk("stall_npc", NPC, 32'h8);
         if (i == 0) begin
            chk("wrap_e4_ir", IR2, 32'h0000_1000);
            chk("wrap_e4_npc", NPC2, 32'h4);
         end
      end
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_addr", imem_addr, 32'h10);
      stall = 1'b0;
      tick();                                   // edge 14
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", imem_addr, 32'h14);
      chk("resume_valid", 32'(valid), 32'd1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("no_gap", 32'(valid), 32'd1);
      end
      chk("p1_drained", 32'(exp_q.size()), 32'd0);

      // ---- slow memory, redirect while a request is outstanding ----
      reset = 1'b0;
      lat   = 3;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();                                   // edge 2: waiting on addr 0
      chk("p2_req", 32'(imem_req), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      expect_seq(32'h200, 2);
      tick();                                   // edge 3 samples redirect
      redirect = 1'b0;
      chk("p2_flush_valid", 32'(valid), 32'd0);
      chk("p2_hold_req", 32'(imem_req), 32'd1);
      chk("p2_hold_addr", imem_addr, 32'h0);
      drain("p2_drain", 60);

      // ---- redirect coinciding with ack, unaligned target ----
      reset = 1'b0;
      lat   = 0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      tick();                                   // edge 3
      chk("p3_pre_valid", 32'(valid), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h103;
      expect_seq(32'h100, 2);
      tick();                                   // edge 4: redirect + ack
      redirect = 1'b0;
      chk("p3_flush_valid", 32'(valid), 32'd0);
      chk("p3_flush_ir", IR, 32'h0);
      chk("p3_flush_npc", NPC, 32'h0);
      tick();                                   // edge 5
      chk("p3_e5_valid", 32'(valid), 32'd0);
      chk("p3_e5_req", 32'(imem_req), 32'd1);
      chk("p3_e5_addr", imem_addr, 32'h100);
      tick();                                   // edge 6
      chk("p3_e6_valid", 32'(valid), 32'd1);
      drain("p3_drain", 20);

      // ---- async reset pulse mid-request with an ack arriving ----
      reset = 1'b0;
      lat   = 3;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();                                   // waiting on addr 0
      chk("p4_pre_req", 32'(imem_req), 32'd1);
      mem_ovr    = 1'b1;
      ack_force  = 1'b1;
      data_force = 32'hDEAD_BEEF;
      #2 reset = 1'b0;
      #1;
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_valid", 32'(valid), 32'd0);
      chk("async_ir", IR, 32'h0);
      chk("async_npc", NPC, 32'h0);
      tick();                                   // edge with ack, reset low
      chk("rst_ack_valid", 32'(valid), 32'd0);
      chk("rst_ack_req", 32'(imem_req), 32'd0);
      reset   = 1'b1;
      mem_ovr = 1'b0;
      lat     = 0;
      expect_seq(32'h0, 2);
      tick();                                   // edge 1 after reset
      chk("p4_e1_req", 32'(imem_req), 32'd1);
      chk("p4_e1_addr", imem_addr, 32'h0);
      chk("p4_e1_valid", 32'(valid), 32'd0);
      drain("p4_drain", 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch front end feeding the IF/ID pipeline register of the 5-stage processor. Owns the PC, issues requests to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions with their NPC in a small FIFO. This decouples fetch from decode stalls. Accepts the taken-branch redirect (Cond/target from EX/MEM) and flushes all wrong-path work.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: PC loaded at reset; low 2 bits must be 0.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; registered.
- imem_addr  out  32  word address being fetched; registered, stable while imem_req=1.
- imem_ack  in  1  memory returns imem_data this cycle; ignored when imem_req=0.
- imem_data  in  32  instruction word, valid with imem_ack.
- redirect  in  1  taken branch/jump (Cond from EX/MEM).
- redirect_pc  in  32  branch target (ALU output from EX/MEM); low 2 bits forced to 0.
- stall  in  1  downstream cannot accept this cycle.
- valid  out  1  IR/NPC hold a real instruction.
- IR  out  32  FIFO head instruction; 32'h0 (NOP) when valid=0.
- NPC  out  32  address of head instruction + 4; 32'h0 when valid=0.

## Operation
- State machine: IDLE (no request outstanding), WAIT (request outstanding, result kept), DROP (request outstanding, result discarded).
- space = (count_after_this_edge < DEPTH). A request is only outstanding when a FIFO slot is reserved for it.
- IDLE: redirect → pc=redirect_pc, stay IDLE. Else if space → imem_req=1, imem_addr=pc, go WAIT.
- WAIT: redirect with or without ack → flush FIFO, pc=redirect_pc. Ack → IDLE; no ack → DROP; imem_req stays high on the old address until ack.
- WAIT, ack, no redirect → push {imem_data, pc+4}, pc=pc+4. If space remains → stay WAIT with imem_addr=new pc (back-to-back). Else → IDLE, imem_req=0.
- DROP: hold request until ack, discard data. Then IDLE, or straight to WAIT on pc if space. Redirect in DROP → pc=redirect_pc, stay DROP.
- Pop: valid && !stall at the edge removes the head.
- Push and pop may occur on the same edge; count unchanged.
- Redirect overrides push and pop: FIFO count→0, valid=0 next cycle, regardless of stall.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
- Reset (asserted at any time, mid-request included): state IDLE, pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, valid=0, IR=0, NPC=0. An ack arriving during or after reset for a pre-reset request is ignored, since imem_req=0.

## Timing
- All outputs are registered or decoded from registers; no combinational input→output path.
- After reset deasserts: edge 1 → imem_req=1, addr=RESET_PC. With imem_ack tied 1: edge 2 → valid=1, IR=mem[RESET_PC], NPC=RESET_PC+4.
- Steady state with ack tied 1 and no stall: one instruction per cycle.
- Redirect sampled at edge N: valid=0 after N. First target instruction valid after N+2 with zero-latency memory in IDLE/WAIT. Add drain time if in DROP.
- stall held: FIFO fills to DEPTH entries, then imem_req drops. IR/NPC remain constant while stall=1.

## Test plan
- Reset then ack=1, stall=0, mem[a]=a|0x1000 → valid from cycle 2; IR sequence 0x1000, 0x1004, 0x1008…; NPC 4, 8, 12…; one per cycle.
- stall=1 for 10 cycles from cycle 3 → exactly 4 entries held, imem_req=0. IR/NPC frozen at head. Release → 4 buffered instructions drain in order, then fetch resumes with no gap or duplicate.
- ack delayed 3 cycles per request; redirect to 0x200 while WAIT → stale ack data never appears. Next valid IR=mem[0x200], NPC=0x204.
- Redirect and ack on the same edge, with redirect_pc=0x103 → ack data dropped. Fetch restarts at 0x100.
- RESET_PC=32'hFFFF_FFF8 → NPCs FFFF_FFFC, 0000_0000, 0000_0004; addresses wrap cleanly.
- reset pulsed low for 1 cycle mid-WAIT with pending ack → all outputs return to reset values immediately (async). Ack during reset is ignored; refetch starts at RESET_PC.
